// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the framed UART: oversampling constants, parity mode
// encoding, TX/RX FSM state enums and a frame-length helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Baud ticks per serial bit and the tick at which a start bit is re-checked.
    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] START_MID  = 4'd7;
    localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

    // cfg_parity encoding; both 00 and 11 mean "no parity bit".
    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Data bits per frame; anything outside 5..max_bits falls back to max_bits.
    function automatic logic [3:0] eff_bits(input logic [3:0] cfg,
                                            input logic [3:0] max_bits);
        return (cfg >= 4'd5 && cfg <= max_bits) ? cfg : max_bits;
    endfunction

    function automatic logic par_enabled(input logic [1:0] mode);
        return (parity_e'(mode) == PAR_EVEN) || (parity_e'(mode) == PAR_ODD);
    endfunction

    function automatic logic par_is_odd(input logic [1:0] mode);
        return parity_e'(mode) == PAR_ODD;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO used for both UART directions.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_i, wdata_i: push (ignored when full unless a pop happens in the same cycle)
//   rd_i         : pop  (ignored when empty)
//   rdata_o      : head entry, valid whenever empty_o = 0
//   full_o, empty_o, count_o : occupancy, registered (update after the access)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a simultaneous push; an empty FIFO ignores the pop.
    assign do_rd = rd_i && !empty_o;
    assign do_wr = wr_i && (!full_o || do_rd);

    // NOTE: storage has no reset; the pointers and count define validity, and
    // leaving the array unreset lets it map onto plain RAM/register files.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_framed.sv
// -----------------------------------------------------------------------------
// uart_framed
// Full-duplex UART with run-time frame format (5..DATA_LENGTH data bits,
// none/even/odd parity, 1 or 2 stop bits), a shared 16x baud tick generator
// and TX/RX FIFOs. Received words carry their own parity/framing error bits.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   rx / tx             : serial in (asynchronous) / serial out
//   dvsr, enable        : baud divisor (tick every dvsr+1 clk), tick enable
//   cfg_data_bits, cfg_parity, cfg_stop2 : frame format, latched per frame
//   wr_uart, tx_data    : push into TX FIFO
//   tx_full, tx_empty, tx_count, tx_busy : TX FIFO status, frame on the line
//   rd_uart             : pop RX FIFO head
//   rx_data, rx_perr, rx_ferr : RX head word and its error flags
//   rx_empty, rx_full, rx_count : RX FIFO status
//   rx_overrun, clr_overrun     : sticky dropped-frame flag and its clear
//
// Optional build macro UART_LOOPBACK_EN adds input 'loopback': when high the
// receiver listens to the internal TX stream and the tx pin idles at 1.
// -----------------------------------------------------------------------------
module uart_framed
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DVSR_BITS   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    output logic                          tx,
    input  logic [DVSR_BITS-1:0]          dvsr,
    input  logic                          enable,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          wr_uart,
    input  logic [DATA_LENGTH-1:0]        tx_data,
    output logic                          tx_full,
    output logic                          tx_empty,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    input  logic                          rd_uart,
    output logic [DATA_LENGTH-1:0]        rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_overrun,
    input  logic                          clr_overrun
`ifdef UART_LOOPBACK_EN
    ,
    input  logic                          loopback
`endif
);

    localparam logic [3:0] MAX_BITS      = 4'(DATA_LENGTH);
    localparam logic [4:0] TX_BIT_LAST   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] TX_STOP2_LAST = 5'(2 * OVERSAMPLE - 1);

    // -------------------------------------------------------------------------
    // Baud tick generator. Counts down from dvsr to 0 and reloads on the tick,
    // so a new dvsr value is only picked up at the wrap.
    // -------------------------------------------------------------------------
    logic [DVSR_BITS-1:0] baud_cnt_q, baud_cnt_d;
    logic                 tick;

    assign tick = enable && (baud_cnt_q == '0);

    // NOTE: combinational blocks assign a default first so no path can leave
    // a variable unassigned and infer a latch.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        if (tick)        baud_cnt_d = dvsr;
        else if (enable) baud_cnt_d = baud_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) baud_cnt_q <= '0;
        else          baud_cnt_q <= baud_cnt_d;
    end

    // -------------------------------------------------------------------------
    // Serial line routing
    // -------------------------------------------------------------------------
    logic [1:0] rx_sync_q;
    logic       rx_line;
    logic       tx_q;

`ifdef UART_LOOPBACK_EN
    assign rx_line = loopback ? tx_q : rx_sync_q[1];
    assign tx      = loopback ? 1'b1 : tx_q;
`else
    assign rx_line = rx_sync_q[1];
    assign tx      = tx_q;
`endif

    // -------------------------------------------------------------------------
    // TX FIFO and frame preparation
    // -------------------------------------------------------------------------
    logic [DATA_LENGTH-1:0] tx_head;
    logic                   tx_pop;
    logic [3:0]             tx_nbits_cfg;
    logic [DATA_LENGTH-1:0] tx_mask, tx_masked;
    logic                   tx_par_bit;

    uart_sync_fifo #(
        .WIDTH (DATA_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_i    (wr_uart),
        .wdata_i (tx_data),
        .rd_i    (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    assign tx_nbits_cfg = eff_bits(cfg_data_bits, MAX_BITS);

    // Bits above the configured length are dropped before shifting and before
    // the parity is formed.
    always_comb begin
        tx_mask = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            tx_mask[i] = (i < int'(tx_nbits_cfg));
        end
        tx_masked  = tx_head & tx_mask;
        tx_par_bit = (^tx_masked) ^ par_is_odd(cfg_parity);
    end

    // -------------------------------------------------------------------------
    // TX FSM
    // -------------------------------------------------------------------------
    tx_state_e              tx_state_q;
    logic [4:0]             tx_tick_q;
    logic [3:0]             tx_bit_q;
    logic [3:0]             tx_nbits_q;
    logic                   tx_par_en_q;
    logic                   tx_par_q;
    logic                   tx_stop2_q;
    logic [DATA_LENGTH-1:0] tx_shift_q;
    logic                   tx_busy_q;
    logic [4:0]             tx_stop_last;

    assign tx_stop_last = tx_stop2_q ? TX_STOP2_LAST : TX_BIT_LAST;
    assign tx_busy      = tx_busy_q;

    // A new frame starts from IDLE or straight out of the last stop tick, so
    // queued words go out back to back without an idle gap.
    assign tx_pop = tick && !tx_empty &&
                    ((tx_state_q == TX_IDLE) ||
                     (tx_state_q == TX_STOP && tx_tick_q == tx_stop_last));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q  <= TX_IDLE;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_nbits_q  <= MAX_BITS;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
        end else if (tx_pop) begin
            tx_state_q  <= TX_START;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_nbits_q  <= tx_nbits_cfg;
            tx_par_en_q <= par_enabled(cfg_parity);
            tx_par_q    <= tx_par_bit;
            tx_stop2_q  <= cfg_stop2;
            tx_shift_q  <= tx_masked;
            tx_q        <= 1'b0;
            tx_busy_q   <= 1'b1;
        end else if (tick) begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                end
                TX_START: begin
                    if (tx_tick_q == TX_BIT_LAST) begin
                        tx_tick_q  <= '0;
                        tx_state_q <= TX_DATA;
                        tx_q       <= tx_shift_q[0];
                    end else begin
                        tx_tick_q <= tx_tick_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick_q == TX_BIT_LAST) begin
                        tx_tick_q <= '0;
                        if (tx_bit_q == tx_nbits_q - 4'd1) begin
                            tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP;
                            tx_q       <= tx_par_en_q ? tx_par_q : 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_tick_q <= tx_tick_q + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (tx_tick_q == TX_BIT_LAST) begin
                        tx_tick_q  <= '0;
                        tx_state_q <= TX_STOP;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_tick_q <= tx_tick_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    // The FIFO-empty case lands here; a pending word was
                    // already taken by the tx_pop branch above.
                    if (tx_tick_q == tx_stop_last) begin
                        tx_tick_q  <= '0;
                        tx_state_q <= TX_IDLE;
                        tx_busy_q  <= 1'b0;
                    end else begin
                        tx_tick_q <= tx_tick_q + 1'b1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_q       <= 1'b1;
                    tx_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RX input synchroniser and edge detection (line idles high)
    // -------------------------------------------------------------------------
    logic rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
            rx_prev_q <= rx_line;
        end
    end

    assign rx_fall = rx_prev_q && !rx_line;

    // -------------------------------------------------------------------------
    // RX FSM
    // -------------------------------------------------------------------------
    rx_state_e              rx_state_q;
    logic [3:0]             rx_tick_q;
    logic [3:0]             rx_bit_q;
    logic [3:0]             rx_nbits_q;
    logic                   rx_par_en_q;
    logic                   rx_par_odd_q;
    logic [DATA_LENGTH-1:0] rx_data_q;
    logic                   rx_perr_q;
    logic                   rx_push;
    logic [DATA_LENGTH+1:0] rx_word;
    logic [DATA_LENGTH+1:0] rx_head;
    logic                   rx_overrun_q;

    // The word is written at the centre of the first stop bit; a low sample
    // there is a framing error.
    assign rx_push = tick && (rx_state_q == RX_STOP) && (rx_tick_q == TICK_LAST);
    assign rx_word = {~rx_line, rx_perr_q, rx_data_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_nbits_q   <= MAX_BITS;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_data_q    <= '0;
            rx_perr_q    <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (enable && rx_fall) begin
                        rx_state_q   <= RX_START;
                        rx_tick_q    <= '0;
                        rx_bit_q     <= '0;
                        rx_nbits_q   <= tx_nbits_cfg;
                        rx_par_en_q  <= par_enabled(cfg_parity);
                        rx_par_odd_q <= par_is_odd(cfg_parity);
                        rx_data_q    <= '0;
                        rx_perr_q    <= 1'b0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tick_q == START_MID) begin
                            // High at mid start bit: a glitch, not a frame.
                            rx_tick_q  <= '0;
                            rx_state_q <= rx_line ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick_q <= rx_tick_q + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_tick_q == TICK_LAST) begin
                            rx_tick_q <= '0;
                            for (int i = 0; i < DATA_LENGTH; i++) begin
                                if (i == int'(rx_bit_q)) rx_data_q[i] <= rx_line;
                            end
                            if (rx_bit_q == rx_nbits_q - 4'd1) begin
                                rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + 1'b1;
                            end
                        end else begin
                            rx_tick_q <= rx_tick_q + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        if (rx_tick_q == TICK_LAST) begin
                            rx_tick_q  <= '0;
                            rx_perr_q  <= rx_line ^ (^rx_data_q) ^ rx_par_odd_q;
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_tick_q <= rx_tick_q + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_tick_q == TICK_LAST) begin
                            rx_tick_q  <= '0;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_tick_q <= rx_tick_q + 1'b1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Set has priority over a simultaneous clear so no drop goes unreported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                rx_overrun_q <= 1'b0;
        else if (rx_push && rx_full) rx_overrun_q <= 1'b1;
        else if (clr_overrun)        rx_overrun_q <= 1'b0;
    end

    assign rx_overrun = rx_overrun_q;

    uart_sync_fifo #(
        .WIDTH (DATA_LENGTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_i    (rx_push),
        .wdata_i (rx_word),
        .rd_i    (rd_uart),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign rx_data = rx_head[DATA_LENGTH-1:0];
    assign rx_perr = rx_head[DATA_LENGTH];
    assign rx_ferr = rx_head[DATA_LENGTH+1];

endmodule

// File: doc/uart_framed.md
Name: uart_framed

Overview:
Next-generation UART: full-duplex serial TX/RX with a shared 16x-oversampling baud generator and RX/TX FIFOs of parametrised depth.
- Frame format is configurable at run time: 5..DATA_LENGTH data bits, none/even/odd parity, 1 or 2 stop bits.
- Per-frame parity and framing errors are stored with each received word; overrun is a sticky flag.
- Sits between the processor-side register interface and the rx/tx pins.

Parameters:
DATA_LENGTH, 8, maximum data bits per frame (legal 5..9)
FIFO_DEPTH, 16, entries per FIFO (power of two, >=2)
DVSR_BITS, 16, baud divisor width

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rx  input  1  serial in (asynchronous)
tx  output  1  serial out
dvsr  input  DVSR_BITS  baud divisor; tick period = dvsr+1 clk
enable  input  1  baud generator enable
cfg_data_bits  input  4  data bits per frame (5..DATA_LENGTH)
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  1 = two stop bits
wr_uart  input  1  push tx_data into TX FIFO
tx_data  input  DATA_LENGTH  word to transmit
tx_full  output  1  TX FIFO full
tx_empty  output  1  TX FIFO empty
tx_busy  output  1  frame on the line
tx_count  output  log2(FIFO_DEPTH)+1  TX FIFO occupancy
rd_uart  input  1  pop RX FIFO head
rx_data  output  DATA_LENGTH  RX head data (first-word fall-through)
rx_perr  output  1  parity error of head word
rx_ferr  output  1  framing error of head word
rx_empty  output  1  RX FIFO empty
rx_full  output  1  RX FIFO full
rx_count  output  log2(FIFO_DEPTH)+1  RX FIFO occupancy
rx_overrun  output  1  sticky: a frame was dropped
clr_overrun  input  1  clears rx_overrun

Behaviour:
- Reset (asynchronous, immediate): tx=1; tx_busy=0; rx_overrun=0; both FIFOs empty (empty=1, full=0, count=0); FSMs IDLE. rx_data/rx_perr/rx_ferr are don't-care while rx_empty=1.
- Baud generator: counter 0..dvsr; one-clk tick when count==dvsr. dvsr=0 ticks every clk. A dvsr change takes effect at the next wrap.
- enable=0: tick suppressed; both FSMs freeze in place.
- Oversampling: 16 ticks per bit.
- Frame config: cfg_* sampled at frame start (TX load, RX start detect) and held for the whole frame. cfg_data_bits outside 5..DATA_LENGTH is treated as DATA_LENGTH.
- Bit order: LSB first. Even parity = XOR of data bits; odd = its inverse.
- rx is passed through a 2-flop synchroniser before any use.
- TX FSM, IDLE->START->DATA->PARITY->STOP->IDLE:
  - IDLE with TX FIFO non-empty: pop the head in the same cycle; tx_busy=1; tx=0 for 16 ticks.
  - DATA: N bits, 16 ticks each.
  - PARITY: skipped when cfg_parity is none.
  - STOP: tx=1 for 16 or 32 ticks.
  - Back-to-back frames have no idle gap.
  - tx_data bits above N are ignored.
- RX FSM, IDLE->START->DATA->PARITY->STOP->IDLE:
  - IDLE: falling edge on synchronised rx enters START.
  - START: at tick 7 re-sample. If high, treat as a glitch and return to IDLE; if low, reset the tick count.
  - DATA: sample at tick 15 of each bit (bit centre).
  - STOP: sample the first stop bit at its centre; ferr = (sample==0). The second stop bit is not checked.
  - Write {ferr, perr, data} to the RX FIFO at the stop-bit sample. Data bits above N are 0.
  - Return to IDLE immediately after the write.
- RX FIFO full at write time: frame dropped, rx_overrun=1.
- rx_overrun: clr_overrun clears it; a simultaneous set wins.
- FIFO rules (both FIFOs):
  - Write when full is ignored.
  - Read when empty is ignored.
  - Simultaneous read+write when full: both proceed, count unchanged.
  - Simultaneous read+write when empty: write only.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flags and count update the cycle after the write/read.
  - Read latency 0 (head always presented).

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds input port loopback (1 bit, after clr_overrun). When loopback=1, the RX FSM input is the internal serial TX stream (bypassing the synchroniser) and the tx pin is held at 1. Switching loopback mid-frame may corrupt that frame only.
- Undefined: no port; RX always uses the rx pin.

Decomposition:
- Package uart_pkg: parity-mode constants, TX/RX state enums, OVERSAMPLE=16, START_MID=7.
- Sub-module uart_sync_fifo (params WIDTH, DEPTH), instantiated twice: TX at width DATA_LENGTH, RX at width DATA_LENGTH+2.
- Baud generator, TX FSM and RX FSM live in the top module.

Test Plan:
- TX 8N1, dvsr=3 (64 clk/bit), write 0xA5 -> tx: 0 for 64 clk, then 1,0,1,0,0,1,0,1, then 1. Frame = 640 clk; tx_busy high throughout.
- RX 7E1, drive 0x41 with parity 0 -> rx_empty falls, rx_data=0x41, perr=0, ferr=0. Resend with parity 1 -> perr=1.
- RX 8N1 frame 0x3C with stop bit 0 -> rx_data=0x3C, ferr=1. A following good frame gives ferr=0.
- FIFO_DEPTH=4, send 5 RX frames with no reads -> rx_full=1 and rx_count=4 after frame 4. Frame 5 dropped, rx_overrun=1. clr_overrun -> 0.
- rx low for 5 ticks, then high -> no FIFO write, FSM back in IDLE.
- reset_n asserted mid TX data bit with 3 words queued -> tx=1 immediately, tx_count=0, tx_busy=0. No output after release.
